// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE = 8;
  localparam int MID_SAMPLE = 3;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for rx plus baud_clk rising-edge detector.
// rx_s lags rx by 2 cycles; tick is combinational off baud_clk and one flop, no backpressure.
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic baud_clk,
  input  logic rx,
  output logic rx_s,
  output logic tick
);

  logic rx_m_q, rx_m_d;
  logic rx_s_q, rx_s_d;
  logic baud_q, baud_d;

  always_comb begin
    rx_m_d = rx;
    rx_s_d = rx_m_q;
    baud_d = baud_clk;
  end

  // Synchronizer resets to the idle-high line level so reset cannot look like a start bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      baud_q <= 1'b0;
    end else begin
      rx_m_q <= rx_m_d;
      rx_s_q <= rx_s_d;
      baud_q <= baud_d;
    end
  end

  assign rx_s = rx_s_q;
  assign tick = baud_clk & ~baud_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8x oversampled, LSB first, optional parity, one stop bit.
// data_valid pulses on the stop-bit tick (~mid stop bit); no backpressure, frames are never held.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_clk,
  input  logic                 rx,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [2:0]    LAST_SAMPLE = 3'(OVERSAMPLE - 1);
  localparam logic [2:0]    MID         = 3'(MID_SAMPLE);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

  logic rx_s;
  logic tick;

  uart_rx_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .baud_clk (baud_clk),
    .rx       (rx),
    .rx_s     (rx_s),
    .tick     (tick)
  );

  rx_state_t            state_q, state_d;
  logic [2:0]           scnt_q, scnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_en_q, par_en_d;
  logic                 par_odd_q, par_odd_d;
  logic                 par_mis_q, par_mis_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 armed_q, armed_d;

  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    bcnt_d    = bcnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_odd_d = par_odd_q;
    par_mis_d = par_mis_q;
    valid_d   = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    armed_d   = armed_q;

    if (tick) begin
      scnt_d = scnt_q + 3'd1;
    end

    case (state_q)
      IDLE: begin
        scnt_d = '0;
        if (rx_s) begin
          armed_d = 1'b1;
        end
        // Parity mode is frozen here so mid-frame changes cannot corrupt the check.
        if (armed_q && !rx_s) begin
          state_d   = START;
          par_en_d  = parity_en;
          par_odd_d = parity_odd;
          par_mis_d = 1'b0;
        end
      end
      START: begin
        if (tick && scnt_q == MID) begin
          scnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
            bcnt_d  = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick && scnt_q == LAST_SAMPLE) begin
          shift_d = DATA_BITS'({rx_s, shift_q} >> 1);
          bcnt_d  = bcnt_q + 1'b1;
          if (bcnt_q == LAST_BIT) begin
            state_d = par_en_q ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (tick && scnt_q == LAST_SAMPLE) begin
          par_mis_d = (^shift_q) ^ rx_s ^ par_odd_q;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (tick && scnt_q == LAST_SAMPLE) begin
          data_d  = shift_q;
          valid_d = 1'b1;
          ferr_d  = ~rx_s;
          perr_d  = par_en_q & par_mis_q;
          // A low stop bit may be a break; wait for the line to go high before re-arming.
          if (!rx_s) begin
            armed_d = 1'b0;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      scnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      par_mis_q <= 1'b0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      armed_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      scnt_q    <= scnt_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      par_mis_q <= par_mis_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      armed_q   <= armed_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames, parity, break, false start, reset, back-to-back.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       baud_clk = 1'b0;
  logic       rx = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int total = 0;
  int bad = 0;
  int half = 83;   // baud modulus + 1
  int cyc = 0;
  int vcount = 0;
  int run = 0;
  int max_run = 0;
  int v0;
  int nv;
  int t_valid[$];
  logic [7:0] v_dat[$];
  logic       v_perr = 1'b0;
  logic       v_ferr = 1'b0;

  uart_rx dut (
    .clk        (clk),
    .reset      (reset),
    .baud_clk   (baud_clk),
    .rx         (rx),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (half) @(negedge clk);
      baud_clk = ~baud_clk;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (data_valid) begin
        run++;
        if (run > max_run) max_run = run;
        vcount++;
        t_valid.push_back(cyc);
        v_dat.push_back(data_out);
        v_perr = parity_err;
        v_ferr = frame_err;
      end else begin
        run = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    hold(16 * half);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (pen) send_bit(pbit);
    send_bit(stop);
  endtask

  initial begin
    // reset state
    hold(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_data", 32'(data_out), 32'h00);
    check("rst_perr", 32'(parity_err), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    reset = 1'b1;
    hold(40);

    // 1: 0xA5 8N1 at modulus 82
    half = 83;
    hold(200);
    v0 = vcount;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    check("t1_count", 32'(vcount - v0), 32'd1);
    check("t1_data", 32'(v_dat[$]), 32'hA5);
    check("t1_ferr", 32'(v_ferr), 32'd0);
    check("t1_perr", 32'(v_perr), 32'd0);
    check("t1_width", 32'(max_run), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_hold", 32'(data_out), 32'hA5);

    // shorter modulus for the long-hold cases
    half = 11;
    hold(400);

    // 2: even parity on 0x03
    parity_en = 1'b1;
    parity_odd = 1'b0;
    v0 = vcount;
    send_frame(8'h03, 1'b1, 1'b0, 1'b1);
    check("t2a_count", 32'(vcount - v0), 32'd1);
    check("t2a_data", 32'(v_dat[$]), 32'h03);
    check("t2a_perr", 32'(v_perr), 32'd0);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    check("t2b_count", 32'(vcount - v0), 32'd2);
    check("t2b_data", 32'(v_dat[$]), 32'h03);
    check("t2b_perr", 32'(v_perr), 32'd1);
    check("t2b_ferr", 32'(v_ferr), 32'd0);
    parity_en = 1'b0;
    hold(16 * half);

    // 3: 0x5A with low stop bit, then break held for 20 bit periods
    v0 = vcount;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b0);
    hold(19 * 16 * half);
    check("t3_count", 32'(vcount - v0), 32'd1);
    check("t3_data", 32'(v_dat[$]), 32'h5A);
    check("t3_ferr", 32'(v_ferr), 32'd1);
    check("t3_perr", 32'(v_perr), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    hold(2 * 16 * half);
    check("t3_rearm_count", 32'(vcount - v0), 32'd1);

    // 4: false start, 2 ticks low
    v0 = vcount;
    rx = 1'b0;
    hold(2 * 2 * half);
    check("t4_busy_start", 32'(busy), 32'd1);
    rx = 1'b1;
    hold(4 * 2 * half);
    check("t4_busy_end", 32'(busy), 32'd0);
    hold(16 * half);
    check("t4_count", 32'(vcount - v0), 32'd0);

    // 5: reset pulse during bit 4 of 0xFF
    v0 = vcount;
    rx = 1'b0;
    hold(16 * half);
    rx = 1'b1;
    hold(4 * 16 * half + 8 * half);
    check("t5_busy_pre", 32'(busy), 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_data", 32'(data_out), 32'h00);
    check("t5_valid", 32'(data_valid), 32'd0);
    check("t5_perr", 32'(parity_err), 32'd0);
    check("t5_ferr", 32'(frame_err), 32'd0);
    hold(5 * 16 * half);
    check("t5_nopulse", 32'(vcount - v0), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    check("t5_count", 32'(vcount - v0), 32'd1);
    check("t5_rx_data", 32'(v_dat[$]), 32'h3C);
    check("t5_rx_ferr", 32'(v_ferr), 32'd0);

    // 6: 0x00 then 0xFF back to back at modulus 82
    half = 83;
    hold(16 * half);
    nv = vcount;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    check("t6_count", 32'(vcount - nv), 32'd2);
    if (vcount - nv == 2) begin
      check("t6_data0", 32'(v_dat[nv]), 32'h00);
      check("t6_data1", 32'(v_dat[nv + 1]), 32'hFF);
      check("t6_spacing", 32'(t_valid[nv + 1] - t_valid[nv]), 32'(10 * 16 * 83));
    end
    check("t6_ferr", 32'(v_ferr), 32'd0);
    check("t6_width", 32'(max_run), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
